// File: rtl/pulse_train_pkg.sv
// Shared types and constants for the pulse train generator.
package pulse_train_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // Shortest legal phase; a programmed length of 0 is stretched to this.
  localparam int unsigned MIN_PHASE_LEN = 1;

endpackage

// File: rtl/phase_down_counter.sv
// Loadable down-counter shared by the HIGH and LOW phases; zero marks the last
// cycle of the current phase.
module phase_down_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] count_r;

  assign zero = (count_r == {CNT_W{1'b0}});

  // Count register: load has priority, then decrement saturating at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (en && !zero) begin
      count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/pulse_train_generator.sv
// Registered pulse train generator: N pulses of H cycles high separated by L low.
// Build option PULSE_TRAIN_CONTINUOUS_EN turns num_pulses=0 into an endless train.
module pulse_train_generator #(
  parameter int CNT_W = 8,
  parameter int NUM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic [NUM_W-1:0] num_pulses,
  input  logic             abort,
  output logic             out,
  output logic             busy,
  output logic             done
);
  import pulse_train_pkg::*;

  // Phase counter reload value: effective length minus one, since the loaded
  // cycle itself is the first cycle of the phase.
  function automatic logic [CNT_W-1:0] phase_reload(input logic [CNT_W-1:0] len);
    logic [CNT_W-1:0] len_eff;
    len_eff = (len < CNT_W'(MIN_PHASE_LEN)) ? CNT_W'(MIN_PHASE_LEN) : len;
    return len_eff - {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_t           state_r, state_next_s;
  logic [CNT_W-1:0] high_rl_r, low_rl_r;
  logic [NUM_W-1:0] remaining_r, remaining_next_s;
  logic             cont_r, cont_next_s;
  logic             latch_s, done_next_s;
  logic             cnt_load_s, cnt_en_s, cnt_zero_s;
  logic [CNT_W-1:0] cnt_load_val_s;
  logic             out_r, busy_r, done_r;

  phase_down_counter #(.CNT_W(CNT_W)) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_s),
    .load_val (cnt_load_val_s),
    .en       (cnt_en_s),
    .zero     (cnt_zero_s)
  );

  // Next-state, phase counter control and pulse bookkeeping.
  always_comb begin
    state_next_s     = state_r;
    remaining_next_s = remaining_r;
    cont_next_s      = cont_r;
    latch_s          = 1'b0;
    done_next_s      = 1'b0;
    cnt_load_s       = 1'b0;
    cnt_en_s         = 1'b0;
    cnt_load_val_s   = high_rl_r;
    case (state_r)
      IDLE: begin
        if (start && !abort) begin
          latch_s          = 1'b1;
          remaining_next_s = num_pulses;
          cont_next_s      = 1'b0;
          if (num_pulses != {NUM_W{1'b0}}) begin
            state_next_s   = HIGH;
            cnt_load_s     = 1'b1;
            cnt_load_val_s = phase_reload(high_len);
          end else begin
`ifdef PULSE_TRAIN_CONTINUOUS_EN
            state_next_s   = HIGH;
            cnt_load_s     = 1'b1;
            cnt_load_val_s = phase_reload(high_len);
            cont_next_s    = 1'b1;
`else
            done_next_s    = 1'b1;
`endif
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      HIGH: begin
        if (abort) begin
          state_next_s = IDLE;
        end else if (!cnt_zero_s) begin
          cnt_en_s = 1'b1;
        end else if (!cont_r && (remaining_r == NUM_W'(1))) begin
          state_next_s     = IDLE;
          remaining_next_s = {NUM_W{1'b0}};
          done_next_s      = 1'b1;
        end else begin
          state_next_s   = LOW;
          cnt_load_s     = 1'b1;
          cnt_load_val_s = low_rl_r;
          if (!cont_r) begin
            remaining_next_s = remaining_r - NUM_W'(1);
          end else begin
            remaining_next_s = remaining_r;
          end
        end
      end
      LOW: begin
        if (abort) begin
          state_next_s = IDLE;
        end else if (!cnt_zero_s) begin
          cnt_en_s = 1'b1;
        end else begin
          state_next_s   = HIGH;
          cnt_load_s     = 1'b1;
          cnt_load_val_s = high_rl_r;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, latched train parameters and output flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      high_rl_r   <= {CNT_W{1'b0}};
      low_rl_r    <= {CNT_W{1'b0}};
      remaining_r <= {NUM_W{1'b0}};
      cont_r      <= 1'b0;
      out_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      remaining_r <= remaining_next_s;
      cont_r      <= cont_next_s;
      out_r       <= (state_next_s == HIGH);
      busy_r      <= (state_next_s != IDLE);
      done_r      <= done_next_s;
      if (latch_s) begin
        high_rl_r <= phase_reload(high_len);
        low_rl_r  <= phase_reload(low_len);
      end else begin
        high_rl_r <= high_rl_r;
        low_rl_r  <= low_rl_r;
      end
    end
  end

  assign out  = out_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_pulse_train_generator.sv
// Self-checking bench for pulse_train_generator against a waveform-list model.
module tb_pulse_train_generator;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] high_len = 8'd0;
  logic [7:0] low_len = 8'd0;
  logic [7:0] num_pulses = 8'd0;
  logic       abort = 1'b0;
  logic       out, busy, done;

  int n_checks = 0;
  int n_pass = 0;

  pulse_train_generator #(.CNT_W(8), .NUM_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .high_len(high_len), .low_len(low_len),
    .num_pulses(num_pulses), .abort(abort), .out(out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic scramble();
    high_len   = 8'($urandom_range(0, 7));
    low_len    = 8'($urandom_range(0, 7));
    num_pulses = 8'($urandom_range(0, 5));
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({out, busy, done} !== 3'b000) $display("FAIL reset_state: got %b want 000", {out, busy, done});
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Model: N blocks of max(H,1) ones, separated by max(L,1) zeros, then done.
  task automatic test_waveform(input int h, input int l, input int n, input bit disturb);
    bit exp_q[$];
    int he, le, rises;
    bit prev;
    he = (h == 0) ? 1 : h;
    le = (l == 0) ? 1 : l;
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < he; c++) exp_q.push_back(1'b1);
      if (p < n - 1) for (int c = 0; c < le; c++) exp_q.push_back(1'b0);
    end
    @(negedge clk);
    start = 1'b1; high_len = 8'(h); low_len = 8'(l); num_pulses = 8'(n);
    @(negedge clk);
    start = 1'b0;
    scramble();
`ifdef PULSE_TRAIN_CONTINUOUS_EN
    if (n == 0) begin
      for (int i = 0; i < 3 * (he + le); i++) begin
        n_checks++;
        if (out !== ((i % (he + le)) < he) || busy !== 1'b1 || done !== 1'b0)
          $display("FAIL endless_cycle%0d: got out=%b busy=%b done=%b want out=%b busy=1 done=0",
                   i, out, busy, done, ((i % (he + le)) < he));
        else n_pass++;
        @(negedge clk);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_checks++;
      if ({out, busy, done} !== 3'b000) $display("FAIL endless_abort: got %b want 000", {out, busy, done});
      else n_pass++;
      return;
    end
`endif
    rises = 0;
    prev = 1'b0;
    foreach (exp_q[i]) begin
      n_checks++;
      if (out !== exp_q[i] || busy !== 1'b1 || done !== 1'b0)
        $display("FAIL train_h%0d_l%0d_n%0d_cycle%0d: got out=%b busy=%b done=%b want out=%b busy=1 done=0",
                 h, l, n, i, out, busy, done, exp_q[i]);
      else n_pass++;
      if (out === 1'b1 && prev === 1'b0) rises++;
      prev = out;
      if (disturb && i == 1) begin
        start = 1'b1;
        scramble();
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++;
    if ({out, busy, done} !== 3'b001)
      $display("FAIL done_h%0d_l%0d_n%0d: got out/busy/done=%b want 001", h, l, n, {out, busy, done});
    else n_pass++;
    n_checks++;
    if (rises != n) $display("FAIL pulse_count_h%0d_l%0d: got %0d want %0d", h, l, rises, n);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({out, busy, done} !== 3'b000)
      $display("FAIL idle_after_h%0d_l%0d_n%0d: got %b want 000", h, l, n, {out, busy, done});
    else n_pass++;
  endtask

  task automatic test_reset_mid_train();
    @(negedge clk);
    start = 1'b1; high_len = 8'd4; low_len = 8'd2; num_pulses = 8'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out, busy} !== 2'b11) $display("FAIL pre_reset_active: got %b want 11", {out, busy});
    else n_pass++;
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if ({out, busy, done} !== 3'b000) $display("FAIL async_reset: got %b want 000", {out, busy, done});
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    test_waveform(3, 2, 2, 1'b0);
  endtask

  task automatic test_abort();
    bit exp_q[$] = '{1, 1, 1, 1, 0, 0, 1, 1};
    @(negedge clk);
    start = 1'b1; high_len = 8'd4; low_len = 8'd2; num_pulses = 8'd3;
    @(negedge clk);
    start = 1'b0;
    foreach (exp_q[i]) begin
      n_checks++;
      if (out !== exp_q[i]) $display("FAIL abort_prefix_cycle%0d: got %b want %b", i, out, exp_q[i]);
      else n_pass++;
      if (i == exp_q.size() - 1) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({out, busy, done} !== 3'b000) $display("FAIL abort_cycle%0d: got %b want 000", i, {out, busy, done});
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1; abort = 1'b1; high_len = 8'd2; low_len = 8'd1; num_pulses = 8'd2;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({out, busy, done} !== 3'b000) $display("FAIL start_abort_idle%0d: got %b want 000", i, {out, busy, done});
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    bit exp1[$] = '{1, 1, 0, 1, 1};
    bit exp2[$] = '{1, 0, 0, 1};
    @(negedge clk);
    start = 1'b1; high_len = 8'd2; low_len = 8'd1; num_pulses = 8'd2;
    @(negedge clk);
    start = 1'b0;
    foreach (exp1[i]) begin
      n_checks++;
      if (out !== exp1[i]) $display("FAIL b2b_first_cycle%0d: got %b want %b", i, out, exp1[i]);
      else n_pass++;
      @(negedge clk);
    end
    n_checks++;
    if (done !== 1'b1) $display("FAIL b2b_done: got %b want 1", done);
    else n_pass++;
    start = 1'b1; high_len = 8'd1; low_len = 8'd2; num_pulses = 8'd2;
    @(negedge clk);
    start = 1'b0;
    foreach (exp2[i]) begin
      n_checks++;
      if (out !== exp2[i] || busy !== 1'b1)
        $display("FAIL b2b_second_cycle%0d: got out=%b busy=%b want out=%b busy=1", i, out, busy, exp2[i]);
      else n_pass++;
      @(negedge clk);
    end
    n_checks++;
    if ({out, busy, done} !== 3'b001) $display("FAIL b2b_second_done: got %b want 001", {out, busy, done});
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int t = 0; t < 25; t++) begin
      test_waveform($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 4),
                    1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_waveform(1, 1, 3, 1'b0);
    test_waveform(2, 3, 2, 1'b0);
    test_waveform(0, 0, 2, 1'b0);
    test_waveform(3, 1, 0, 1'b0);
    test_waveform(2, 2, 3, 1'b1);
    test_reset_mid_train();
    test_abort();
    test_start_abort_idle();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pulse_train_generator.md
Name: pulse_train_generator

Overview:
Transmit-side counterpart to the team's edge and one-cycle-pulse detectors. On a start strobe it drives a registered single-bit output with a programmable train of pulses: N pulses, each H cycles high, separated by L cycles low. Used to stimulate and drive pulse/edge-detector paths, and as a general strobe generator in sequential-basics designs.

Parameters:
CNT_W, 8, width of high_len / low_len phase-length inputs and phase counter
NUM_W, 8, width of num_pulses input and pulse counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low
start  input  1  one-cycle request; sampled only in IDLE
high_len  input  CNT_W  cycles per high phase; 0 treated as 1
low_len  input  CNT_W  cycles per low gap; 0 treated as 1
num_pulses  input  NUM_W  pulses in train
abort  input  1  terminate train immediately
out  output  1  pulse train, registered
busy  output  1  high while a train is in progress
done  output  1  one-cycle strobe on normal completion

Behaviour:
- Reset (rst=0, async): state IDLE, out=0, busy=0, done=0, counters cleared; takes effect immediately, mid-train included. Release synchronous to clk.
- FSM states: IDLE, HIGH, LOW.
- IDLE: start=1 at edge k latches high_len, low_len, num_pulses (later input changes have no effect until next start). If num_pulses>0: out=1, busy=1 after edge k, state HIGH. If num_pulses=0: out stays 0, busy stays 0, done=1 for the cycle after edge k.
- HIGH: out=1 for exactly max(high_len,1) cycles. At end of phase, decrement remaining pulse count; if more remain, go to LOW; otherwise go to IDLE with out=0, busy=0, done=1 (one cycle).
- LOW: out=0 for exactly max(low_len,1) cycles, then HIGH.
- So every pulse is bounded by low cycles on both sides. high_len=1 yields a 010 pattern per pulse.
- The final pulse has no trailing LOW phase. done coincides with the first low cycle after the last pulse.
- Total busy duration = N*H + (N-1)*L cycles.
- start while busy: ignored, no queuing.
- start in the same cycle done=1 is accepted, because the state is already IDLE. The next train begins after that edge.
- abort=1 while busy: at next edge out=0, busy=0, state IDLE, done stays 0.
- abort and start together in IDLE: abort wins, no train.
- abort in IDLE alone: no effect.
- Outputs are glitch-free flops: out, busy and done all come directly from registers.

Optional Feature:
Macro PULSE_TRAIN_CONTINUOUS_EN.
- Defined: num_pulses=0 means an endless train; it runs until abort or reset, and done is never asserted for it.
- Not defined: num_pulses=0 yields no pulses and an immediate done, as above.
- All other behaviour is identical in both builds.

Decomposition:
- Package pulse_train_pkg: state enum type (IDLE, HIGH, LOW), and helper constant for the minimum phase length (1).
- Sub-module phase_down_counter: loadable CNT_W-bit down-counter with load, enable, and a zero flag. Instantiated once and shared by the HIGH and LOW phases.
- The pulse counter stays inline in the top module.

Test Plan:
- Reset mid-train: rst=0 while out=1 → out, busy and done go to 0 immediately, without waiting for clk. After release, a fresh start behaves normally.
- H=1, L=1, N=3, start at edge k → out per cycle after k: 1 0 1 0 1 0; busy for 5 cycles; done=1 in the 6th cycle only. A one_cycle_pulse_detector monitoring out reports 3 detections.
- H=2, L=3, N=2 → out: 1 1 0 0 0 1 1 0; done in the 8th cycle.
- high_len=0, low_len=0, N=2 → same waveform as H=1, L=1: 1 0 1 0.
- num_pulses=0 → out never high, busy never high, done=1 in the cycle after start. With PULSE_TRAIN_CONTINUOUS_EN defined: H=1, L=1 → out toggles 1 0 indefinitely, and abort after 10 cycles gives out=0, busy=0, done=0.
- start pulsed during busy with different lengths → waveform unchanged. abort during the 2nd HIGH phase of H=4, N=3 → out=0 and busy=0 at the next edge, no done. start together with abort in IDLE → no pulse.
